// File: rtl/counter_pkg.sv
// Shared types and the command priority decode for the up/down counter.
package counter_pkg;

    typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_t;

    typedef enum logic [1:0] {CMD_HOLD, CMD_LOAD, CMD_UP, CMD_DOWN} cnt_cmd_t;

    // rst is handled by the register itself and sits above everything decoded here.
    function automatic cnt_cmd_t decode_cmd(input logic load, input logic up, input logic down);
        cnt_cmd_t cmd;
        if (load)
            cmd = CMD_LOAD;
        else if (up && down)
            cmd = CMD_HOLD;
        else if (up)
            cmd = CMD_UP;
        else if (down)
            cmd = CMD_DOWN;
        else
            cmd = CMD_HOLD;
        return cmd;
    endfunction

endpackage

// File: rtl/mod_step_alu.sv
// Combinational step/modulus arithmetic: one count step up or down, with wrap or saturate.
module mod_step_alu
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] cur,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [DATA_WIDTH-1:0] mod_max,
    input  cnt_mode_t             mode,
    input  logic                  dir_up,
    output logic [DATA_WIDTH-1:0] nxt,
    output logic                  flag
);

    localparam int W1 = DATA_WIDTH + 1;

    logic [W1-1:0] cur_x;
    logic [W1-1:0] step_x;
    logic [W1-1:0] max_x;
    logic [W1-1:0] span_x;
    logic [W1-1:0] sum_x;
    logic [W1-1:0] res_x;

    always_comb begin
        cur_x  = W1'(cur);
        step_x = W1'(step);
        max_x  = W1'(mod_max);
        span_x = max_x + W1'(1);
        sum_x  = cur_x + step_x;
        res_x  = cur_x;
        flag   = 1'b0;

        // A value left above a lowered bound snaps back to the bound without an event.
        if (cur_x > max_x) begin
            res_x = max_x;
        end else if (step_x == '0) begin
            res_x = cur_x;
        end else if (dir_up) begin
            if (sum_x > max_x) begin
                flag  = 1'b1;
                res_x = (mode == CNT_SAT) ? max_x : sum_x - span_x;
            end else begin
                res_x = sum_x;
            end
        end else begin
            if (cur_x >= step_x) begin
                res_x = cur_x - step_x;
            end else begin
                flag  = 1'b1;
                res_x = (mode == CNT_SAT) ? '0 : cur_x + span_x - step_x;
            end
        end

        // Within the step <= mod_max+1 contract the top bit is zero; otherwise clamp rather than truncate.
        nxt = res_x[DATA_WIDTH-1:0] | {DATA_WIDTH{res_x[DATA_WIDTH]}};
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, variable step, load and wrap/saturate terminal-count pulses.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  up,
    input  logic                  down,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [DATA_WIDTH-1:0] mod_max,
    input  logic                  sat,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tc_up,
    output logic                  tc_down,
    output logic                  at_max,
    output logic                  at_min
);

    cnt_cmd_t              cmd;
    cnt_mode_t             mode;
    logic [DATA_WIDTH-1:0] alu_nxt;
    logic                  alu_flag;
    logic [DATA_WIDTH-1:0] load_val;

    assign cmd      = decode_cmd(load, up, down);
    assign mode     = sat ? CNT_SAT : CNT_WRAP;
    assign load_val = (din > mod_max) ? mod_max : din;

    mod_step_alu #(
        .DATA_WIDTH(DATA_WIDTH),
        .STEP_WIDTH(STEP_WIDTH)
    ) u_alu (
        .cur    (dout),
        .step   (step),
        .mod_max(mod_max),
        .mode   (mode),
        .dir_up (cmd == CMD_UP),
        .nxt    (alu_nxt),
        .flag   (alu_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= '0;
            tc_up   <= 1'b0;
            tc_down <= 1'b0;
        end else begin
            case (cmd)
                CMD_LOAD: begin
                    dout    <= load_val;
                    tc_up   <= 1'b0;
                    tc_down <= 1'b0;
                end
                CMD_UP: begin
                    dout    <= alu_nxt;
                    tc_up   <= alu_flag;
                    tc_down <= 1'b0;
                end
                CMD_DOWN: begin
                    dout    <= alu_nxt;
                    tc_up   <= 1'b0;
                    tc_down <= alu_flag;
                end
                default: begin
                    tc_up   <= 1'b0;
                    tc_down <= 1'b0;
                end
            endcase
        end
    end

    assign at_max = (dout == mod_max);
    assign at_min = (dout == '0);

endmodule
